// File: rtl/me_result_streamer_if.sv
// Result-capture and beat-stream signals between me_top, the streamer and the host/DMA sink.
// The slave modport is the streamer's view; the master modport drives results and accepts beats.
interface me_result_streamer_if #(
  parameter int M_SIZE = 3072,
  parameter int OUT_W  = 64,
  parameter int TAG_W  = 4
);
  logic              done;
  logic [M_SIZE-1:0] z;
  logic [TAG_W-1:0]  num_out;
  logic [OUT_W-1:0]  out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic [TAG_W-1:0]  out_tag;
  logic              busy;
  logic              overflow;
  logic              clr_overflow;

  modport slave (
    input  done, z, num_out, out_ready, clr_overflow,
    output out_data, out_valid, out_last, out_tag, busy, overflow
  );

  modport master (
    output done, z, num_out, out_ready, clr_overflow,
    input  out_data, out_valid, out_last, out_tag, busy, overflow
  );
endinterface

// File: rtl/me_result_streamer.sv
// Captures modexp results into a 2-deep buffer and streams each one as OUT_W-bit beats,
// least-significant word first, on a valid/ready interface with a sticky overflow flag.
module me_result_streamer #(
  parameter int M_SIZE = 3072,
  parameter int OUT_W  = 64,
  parameter int TAG_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  me_result_streamer_if.slave   bus
);
  localparam int BEATS  = M_SIZE / OUT_W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  logic [OUT_W-1:0] slot_data_q [2][BEATS];
  logic [TAG_W-1:0] slot_tag_q  [2];

  logic [1:0]        count_q,    count_d;
  logic              wr_ptr_q,   wr_ptr_d;
  logic              rd_ptr_q,   rd_ptr_d;
  logic [BEAT_W-1:0] beat_q,     beat_d;
  logic              overflow_q, overflow_d;

  logic out_valid, xfer, last_beat, final_xfer, capture, drop;

  assign out_valid  = (count_q != 2'd0);
  assign xfer       = out_valid && bus.out_ready;
  assign last_beat  = (beat_q == LAST_BEAT);
  assign final_xfer = xfer && last_beat;
  // A full buffer still accepts a result when its oldest entry leaves this same edge.
  assign capture    = bus.done && ((count_q != 2'd2) || final_xfer);
  assign drop       = bus.done && !capture;

  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_valid ? slot_data_q[rd_ptr_q][beat_q] : '0;
  assign bus.out_tag   = out_valid ? slot_tag_q[rd_ptr_q] : '0;
  assign bus.out_last  = out_valid && last_beat;
  assign bus.busy      = out_valid;
  assign bus.overflow  = overflow_q;

  always_comb begin
    // NOTE: every variable gets its default first so no path through this block infers a latch.
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    beat_d     = beat_q;
    overflow_d = overflow_q;

    if (final_xfer) begin
      beat_d   = '0;
      rd_ptr_d = ~rd_ptr_q;
    end else if (xfer) begin
      beat_d = beat_q + 1'b1;
    end

    if (capture) wr_ptr_d = ~wr_ptr_q;

    unique case ({capture, final_xfer})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    // Set wins over clear so a drop in the clearing cycle is never lost.
    if (drop)                  overflow_d = 1'b1;
    else if (bus.clr_overflow) overflow_d = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      beat_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      beat_q     <= beat_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: slot storage has no reset; count_q gates every read, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (capture) begin
      slot_tag_q[wr_ptr_q] <= bus.num_out;
      for (int k = 0; k < BEATS; k++) begin
        slot_data_q[wr_ptr_q][k] <= bus.z[k*OUT_W +: OUT_W];
      end
    end
  end
endmodule

// File: tb/tb_me_result_streamer.sv
// Directed bench for me_result_streamer: latency, backpressure, buffering, full boundary,
// overflow set/clear priority and mid-stream reset, all against hand-computed beat values.
module tb_me_result_streamer;
  localparam int M_SIZE = 3072;
  localparam int OUT_W  = 64;
  localparam int TAG_W  = 4;
  localparam int BEATS  = 48;

  logic clk = 1'b0;
  logic rst_n;

  me_result_streamer_if #(.M_SIZE(M_SIZE), .OUT_W(OUT_W), .TAG_W(TAG_W)) bus ();

  me_result_streamer #(.M_SIZE(M_SIZE), .OUT_W(OUT_W), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Word k of result "seed" is seed*256 + k, so seed 0 gives word k == k.
  function automatic logic [M_SIZE-1:0] make_z(input int seed);
    logic [M_SIZE-1:0] r;
    r = '0;
    for (int k = 0; k < BEATS; k++) r[k*OUT_W +: OUT_W] = 64'(seed * 256 + k);
    return r;
  endfunction

  // Outputs are sampled and inputs driven 1 ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] tg, input int seed);
    bus.done    = 1'b1;
    bus.num_out = tg;
    bus.z       = make_z(seed);
    tick();
    bus.done    = 1'b0;
  endtask

  // Drain one full result with ready held high; optionally fire a done on its final beat.
  task automatic drain(input logic [3:0] tg, input int seed,
                       input bit inj, input logic [3:0] itg, input int iseed);
    bus.out_ready = 1'b1;
    for (int k = 0; k < BEATS; k++) begin
      check("valid", 64'(bus.out_valid), 64'd1);
      check("data",  bus.out_data, 64'(seed * 256 + k));
      check("tag",   64'(bus.out_tag), 64'(tg));
      check("last",  64'(bus.out_last), 64'(k == BEATS - 1));
      if (inj && k == BEATS - 1) begin
        bus.done    = 1'b1;
        bus.num_out = itg;
        bus.z       = make_z(iseed);
      end
      tick();
      bus.done = 1'b0;
    end
  endtask

  initial begin
    int         xfers;
    int         last_cyc;
    logic [63:0] held_data;
    logic        held_last;
    bit          check_hold;

    rst_n            = 1'b0;
    bus.done         = 1'b0;
    bus.z            = '0;
    bus.num_out      = '0;
    bus.out_ready    = 1'b0;
    bus.clr_overflow = 1'b0;
    #1;
    check("rst_valid",    64'(bus.out_valid), 64'd0);
    check("rst_data",     bus.out_data, 64'd0);
    check("rst_busy",     64'(bus.busy), 64'd0);
    check("rst_overflow", 64'(bus.overflow), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Single result with ready high: valid the edge after done, no beat skipped.
    bus.out_ready = 1'b1;
    bus.done      = 1'b1;
    bus.num_out   = 4'd5;
    bus.z         = make_z(0);
    check("lat_pre_valid", 64'(bus.out_valid), 64'd0);
    tick();
    bus.done = 1'b0;
    drain(4'd5, 0, 1'b0, 4'd0, 0);
    check("single_busy_after", 64'(bus.busy), 64'd0);
    check("single_valid_after", 64'(bus.out_valid), 64'd0);

    // Backpressure: ready alternates starting high on the first valid cycle.
    bus.out_ready = 1'b0;
    push(4'd5, 0);
    xfers      = 0;
    last_cyc   = -1;
    check_hold = 1'b0;
    held_data  = '0;
    held_last  = 1'b0;
    for (int cyc = 0; cyc < 200 && xfers < BEATS; cyc++) begin
      bus.out_ready = (cyc % 2 == 0);
      if (check_hold) begin
        check("bp_hold_data", bus.out_data, held_data);
        check("bp_hold_last", 64'(bus.out_last), 64'(held_last));
      end
      check_hold = 1'b0;
      if (bus.out_ready && bus.out_valid) begin
        check("bp_data", bus.out_data, 64'(xfers));
        check("bp_tag",  64'(bus.out_tag), 64'd5);
        check("bp_last", 64'(bus.out_last), 64'(xfers == BEATS - 1));
        xfers++;
        last_cyc = cyc;
      end else if (!bus.out_ready) begin
        held_data  = bus.out_data;
        held_last  = bus.out_last;
        check_hold = 1'b1;
      end
      tick();
    end
    check("bp_xfers", 64'(xfers), 64'd48);
    check("bp_cycles", 64'(last_cyc), 64'd94);
    check("bp_idle", 64'(bus.out_valid), 64'd0);

    // Buffering and overflow: third result is dropped while two are held.
    bus.out_ready = 1'b0;
    push(4'd1, 1);
    push(4'd2, 2);
    check("buf_ovf_before", 64'(bus.overflow), 64'd0);
    push(4'd3, 3);
    check("buf_ovf_set", 64'(bus.overflow), 64'd1);
    check("buf_busy", 64'(bus.busy), 64'd1);
    check("buf_head_tag", 64'(bus.out_tag), 64'd1);
    drain(4'd1, 1, 1'b0, 4'd0, 0);
    drain(4'd2, 2, 1'b0, 4'd0, 0);
    check("buf_empty", 64'(bus.out_valid), 64'd0);
    check("buf_ovf_sticky", 64'(bus.overflow), 64'd1);
    bus.clr_overflow = 1'b1;
    tick();
    bus.clr_overflow = 1'b0;
    check("buf_ovf_clr", 64'(bus.overflow), 64'd0);

    // Full boundary: done on the final beat of a full buffer is accepted.
    bus.out_ready = 1'b0;
    push(4'd4, 4);
    push(4'd6, 6);
    drain(4'd4, 4, 1'b1, 4'd7, 7);
    check("full_no_ovf", 64'(bus.overflow), 64'd0);
    drain(4'd6, 6, 1'b0, 4'd0, 0);
    drain(4'd7, 7, 1'b0, 4'd0, 0);
    check("full_empty", 64'(bus.busy), 64'd0);

    // Overflow clear: set wins over a simultaneous clear, then clear alone.
    bus.out_ready = 1'b0;
    push(4'd8, 8);
    push(4'd9, 9);
    bus.clr_overflow = 1'b1;
    push(4'd10, 10);
    check("clr_set_wins", 64'(bus.overflow), 64'd1);
    tick();
    bus.clr_overflow = 1'b0;
    check("clr_alone", 64'(bus.overflow), 64'd0);
    drain(4'd8, 8, 1'b0, 4'd0, 0);
    drain(4'd9, 9, 1'b0, 4'd0, 0);
    check("clr_empty", 64'(bus.out_valid), 64'd0);

    // Reset mid-stream with a second result buffered behind the partial one.
    bus.out_ready = 1'b0;
    push(4'd11, 11);
    push(4'd12, 12);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    check("mid_beat20", bus.out_data, 64'(11 * 256 + 20));
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_data",  bus.out_data, 64'd0);
    check("mid_rst_busy",  64'(bus.busy), 64'd0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      check("mid_idle", 64'(bus.out_valid), 64'd0);
      tick();
    end
    push(4'd13, 13);
    drain(4'd13, 13, 1'b0, 4'd0, 0);
    check("mid_final_idle", 64'(bus.out_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/me_result_streamer.md
Name: me_result_streamer

Overview:
- Consumer end of the modular-exponentiation result interface (z, done, num_out).
- Captures each full-width result on the done pulse, together with its num_out job tag, into a 2-entry buffer.
- Serializes each result into OUT_W-bit beats on a valid/ready stream, least-significant word first, so results can leave the accelerator over a narrow host/DMA bus.
- Sits directly downstream of me_top; a second result can complete while the first is still draining.

Parameters:
M_SIZE, 3072, result width in bits
OUT_W, 64, stream beat width; M_SIZE must be a multiple of OUT_W
BEATS, M_SIZE/OUT_W (48), beats per result
BEAT_W, 6, beat counter width, ceil(log2(BEATS))
TAG_W, 4, job tag width, matches num_out

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
done  in  1  single-cycle pulse; z and num_out are valid in the same cycle
z  in  M_SIZE  result operand
num_out  in  TAG_W  job tag of the result
out_data  out  OUT_W  current beat; 0 when out_valid=0
out_valid  out  1  beat available
out_ready  in  1  sink accepts beat
out_last  out  1  final beat of a result (out_valid && beat==BEATS-1)
out_tag  out  TAG_W  tag of the result being streamed; held for all beats
busy  out  1  buffer count != 0
overflow  out  1  sticky: a result was dropped
clr_overflow  in  1  synchronous clear of overflow

Behaviour:
- Reset (async, rst_n=0): count=0, wr_ptr=0, rd_ptr=0, beat=0, overflow=0. All outputs are 0 immediately. Slot contents need not be reset.
- Storage: two slots of {tag, M_SIZE data}. count ranges 0..2. wr_ptr and rd_ptr are 1-bit.
- Capture: on a clock edge with done=1 and a slot free (count<2, or a completing final handshake in the same cycle), write {num_out, z} into slot[wr_ptr] and toggle wr_ptr.
- Latency: done sampled at edge N → out_valid=1 from edge N+1 when the buffer was empty.
- Output path, combinational from registers:
  - out_valid = (count != 0)
  - out_data = slot[rd_ptr].data[beat*OUT_W +: OUT_W]
  - out_tag = slot[rd_ptr].tag
- Handshake: a beat transfers when out_valid && out_ready. While out_valid=1 && out_ready=0, out_data, out_tag and out_last stay stable.
- On transfer: if beat < BEATS-1, beat++. Otherwise beat=0, rd_ptr toggles, and count decrements. A back-to-back next result streams with no bubble cycle.
- Count update per edge: count += capture − final_transfer. Simultaneous capture and final transfer leaves count unchanged.
- Full boundary: with count==2 and a final transfer in the same cycle, a done is accepted into the slot being freed. The read uses the old content this cycle; no overflow.
- Overflow: done while count==2 and no final transfer that cycle → result dropped, no state change except overflow=1.
  - clr_overflow=1 clears overflow on the next edge.
  - If a drop and clr_overflow occur in the same cycle, set wins (overflow=1).
- done while the buffer is empty and out_ready=1: first beat is presented at N+1 and is not skipped.
- Reset mid-stream: the partial result and the buffered result are discarded. After reset release there is no output until a new done.
- Tags are passed through unmodified; no reordering, strict FIFO order.

Test Plan:
- Single result: z word k = 64'h0000_0000_0000_00kk (k=0..47), num_out=5, out_ready=1 → out_valid rises the edge after done; 48 beats with out_data=k; out_last only on beat 47; out_tag=5 throughout; busy falls after beat 47.
- Backpressure: same z, out_ready toggles 1/0 each cycle → exactly 48 transfers in order; out_data and out_last stable during ready=0 cycles; 95 cycles from first valid to last transfer.
- Buffering and overflow: with out_ready=0, dones with tags 1, 2, 3 → count=2, overflow=1, tag 3 dropped. Release ready → 96 beats, tag 1 then tag 2, no gap between the two results.
- Full boundary: count==2; fire done (tag 7) in the same cycle as the final beat of the first result → no overflow; tags stream in order (second result, then 7).
- Overflow clear: assert clr_overflow in the same cycle as a new drop → overflow stays 1. Next cycle, clr_overflow alone → overflow=0.
- Reset mid-stream: rst_n low at beat 20 → out_valid, out_data, busy=0 immediately. After release with no done for 10 cycles → out_valid stays 0. Next done streams from beat 0.
